hamming_decoder: RTL and testbench



---
 rtl/hamming_decoder.sv | 151 +++++++++++++++
 tb/tb_hamming_decoder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// SECDED extended-Hamming decoder: two-stage pipeline with a valid/ready stream.
// Define HAMMING_DEC_ERR_CNT_EN to add saturating SEC/DED event counters.
module hamming_decoder #(
    parameter int P_BITS    = 3,
    parameter int OP_WIDTH  = (1 << P_BITS) - 1,
    parameter int IP_WIDTH  = (1 << P_BITS) - P_BITS - 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_WIDTH:0]    in_cw,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [IP_WIDTH-1:0]  out_data,
    output logic [P_BITS-1:0]    out_syndrome,
    output logic                 out_single_err,
    output logic                 out_double_err,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef HAMMING_DEC_ERR_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] sec_count,
    output logic [CNT_WIDTH-1:0] ded_count
`endif
);

    if (P_BITS < 2 || P_BITS > 6 || CNT_WIDTH < 1) begin : g_bad_param
        $error("hamming_decoder: illegal parameter set");
    end

    // Data bits occupy every non-power-of-two position above 0, ascending.
    function automatic logic [IP_WIDTH-1:0] extract(input logic [OP_WIDTH:0] cw);
        int j;
        extract = '0;
        j = 0;
        for (int i = 3; i <= OP_WIDTH; i++) begin
            if ((i & (i - 1)) != 0) begin
                extract[j] = cw[i];
                j++;
            end
        end
    endfunction

    logic                s1_en;
    logic                s2_en;

    logic                s1_valid_q;
    logic [OP_WIDTH:0]   s1_cw_q;
    logic [P_BITS-1:0]   s1_syn_q;
    logic                s1_par_q;

    logic [P_BITS-1:0]   syn_d;
    logic                par_d;

    logic                s2_valid_q;
    logic [IP_WIDTH-1:0] data_q;
    logic [P_BITS-1:0]   syn_q;
    logic                se_q;
    logic                de_q;

    logic [OP_WIDTH:0]   fix_d;
    logic [IP_WIDTH-1:0] data_d;
    logic                se_d;
    logic                de_d;

    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;

    always_comb begin
        syn_d = '0;
        for (int i = 1; i <= OP_WIDTH; i++) begin
            if (in_cw[i]) syn_d = syn_d ^ P_BITS'(i);
        end
        par_d = ^in_cw;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_cw_q    <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_cw_q  <= in_cw;
                s1_syn_q <= syn_d;
                s1_par_q <= par_d;
            end
        end
    end

    // Odd overall parity means one flip; a zero syndrome then points at bit 0.
    always_comb begin
        fix_d = s1_cw_q;
        if (s1_par_q && s1_syn_q != '0) begin
            fix_d[s1_syn_q] = ~s1_cw_q[s1_syn_q];
        end
        data_d = extract(fix_d);
        se_d   = s1_par_q;
        de_d   = !s1_par_q && (s1_syn_q != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            syn_q      <= '0;
            se_q       <= 1'b0;
            de_q       <= 1'b0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_q <= data_d;
                syn_q  <= s1_syn_q;
                se_q   <= se_d;
                de_q   <= de_d;
            end
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_data       = data_q;
    assign out_syndrome   = syn_q;
    assign out_single_err = se_q;
    assign out_double_err = de_q;

`ifdef HAMMING_DEC_ERR_CNT_EN
    logic                 xfer;
    logic [CNT_WIDTH-1:0] sec_q;
    logic [CNT_WIDTH-1:0] ded_q;

    assign xfer = s2_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            sec_q <= '0;
            ded_q <= '0;
        end else begin
            if (xfer && se_q && !(&sec_q)) sec_q <= sec_q + 1'b1;
            if (xfer && de_q && !(&ded_q)) ded_q <= ded_q + 1'b1;
        end
    end

    assign sec_count = sec_q;
    assign ded_count = ded_q;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: encoder-based reference model,
// random error injection, random backpressure, stall and reset checks.
module tb_hamming_decoder;

    localparam int P  = 3;
    localparam int OW = (1 << P) - 1;
    localparam int IW = (1 << P) - P - 1;

    typedef struct packed {
        logic [IW-1:0] d;
        logic [P-1:0]  s;
        logic          se;
        logic          de;
    } exp_t;

    logic          clk = 0;
    logic          rst_n = 0;
    logic [OW:0]   in_cw = '0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [IW-1:0] out_data;
    logic [P-1:0]  out_syndrome;
    logic          out_single_err;
    logic          out_double_err;
    logic          out_valid;
    logic          out_ready = 0;
`ifdef HAMMING_DEC_ERR_CNT_EN
    logic          cnt_clr = 0;
    logic [15:0]   sec_count;
    logic [15:0]   ded_count;
`endif

    hamming_decoder #(.P_BITS(P)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_cw          (in_cw),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_syndrome   (out_syndrome),
        .out_single_err (out_single_err),
        .out_double_err (out_double_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
`ifdef HAMMING_DEC_ERR_CNT_EN
        ,
        .cnt_clr        (cnt_clr),
        .sec_count      (sec_count),
        .ded_count      (ded_count)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;
    exp_t sb[$];

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = (rdy_mode == 2);
    end

    // Reference encoder: data into non-power-of-two slots, then parity bits.
    function automatic logic [OW:0] encode(input logic [IW-1:0] d);
        logic [OW:0] cw;
        int j;
        cw = '0;
        j = 0;
        for (int i = 1; i <= OW; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[j];
                j++;
            end
        end
        for (int k = 0; k < P; k++) begin
            for (int i = 1; i <= OW; i++) begin
                if (i != (1 << k) && ((i >> k) & 1) != 0) cw[1 << k] ^= cw[i];
            end
        end
        cw[0] = ^cw[OW:1];
        return cw;
    endfunction

    function automatic logic [IW-1:0] extract(input logic [OW:0] cw);
        logic [IW-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 1; i <= OW; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = cw[i];
                j++;
            end
        end
        return d;
    endfunction

    task automatic gen(output logic [OW:0] cw, output exp_t e);
        logic [IW-1:0] d;
        int nerr, a, b;
        d = IW'($urandom);
        cw = encode(d);
        nerr = $urandom_range(0, 2);
        a = $urandom_range(0, OW);
        b = (a + $urandom_range(1, OW)) % (OW + 1);
        e = '{d: d, s: '0, se: 1'b0, de: 1'b0};
        if (nerr == 1) begin
            cw[a] = ~cw[a];
            e.s  = P'(a);
            e.se = 1'b1;
        end else if (nerr == 2) begin
            cw[a] = ~cw[a];
            cw[b] = ~cw[b];
            e.s  = P'(a ^ b);
            e.de = 1'b1;
            e.d  = extract(cw);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [OW:0] cw, input exp_t e);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_cw = cw;
        in_valid = 1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stalled required=accepted");
                done = 1;
            end
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int n;
        rdy_mode = 2;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops on every output transfer, checks stability under stall.
    logic          held_v = 0;
    logic [IW+P+2:0] held;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_v = 0;
        end else begin
            if (held_v) begin
                checks++;
                if ({out_valid, out_data, out_syndrome, out_single_err, out_double_err} !== held) begin
                    errors++;
                    $display("FAIL hold_stable actual=%h required=%h",
                             {out_valid, out_data, out_syndrome, out_single_err, out_double_err}, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected actual=d%h required=no_output", out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_syndrome !== e.s ||
                        out_single_err !== e.se || out_double_err !== e.de) begin
                        errors++;
                        $display("FAIL out_word actual d=%h s=%0d se=%b de=%b required d=%h s=%0d se=%b de=%b",
                                 out_data, out_syndrome, out_single_err, out_double_err,
                                 e.d, e.s, e.se, e.de);
                    end
                end
            end
            held_v = out_valid && !out_ready;
            held = {out_valid, out_data, out_syndrome, out_single_err, out_double_err};
        end
    end

    initial begin
        logic [OW:0] cw;
        exp_t e;
        int acc, cyc;

        rdy_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_syndrome", 32'(out_syndrome), 32'd0);
        chk("rst_flags", 32'({out_single_err, out_double_err}), 32'd0);

        send(8'hAA, '{d: 4'b1011, s: 3'd0, se: 1'b0, de: 1'b0});
        send(8'h8A, '{d: 4'b1011, s: 3'd5, se: 1'b1, de: 1'b0});
        send(8'hAB, '{d: 4'b1011, s: 3'd0, se: 1'b1, de: 1'b0});
        send(8'hAC, '{d: 4'b1011, s: 3'd3, se: 1'b0, de: 1'b1});
        drain();

        // Backpressure: four words against a stalled output.
        rdy_mode = 1;
        @(posedge clk);
        #2;
        acc = 0;
        gen(cw, e);
        in_cw = cw;
        in_valid = 1;
        for (cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (in_ready && in_valid) begin
                sb.push_back(e);
                acc++;
            end
            @(posedge clk);
            #1;
            if (in_ready === 1'b0 || acc == 0 || !in_valid) begin
            end else begin
                gen(cw, e);
                in_cw = cw;
            end
            if (acc >= 4) in_valid = 0;
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        rdy_mode = 2;
        send(cw, e);
        gen(cw, e);
        send(cw, e);
        gen(cw, e);
        send(cw, e);
        drain();

        for (int n = 0; n < 400; n++) begin
            rdy_mode = 0;
            gen(cw, e);
            send(cw, e);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Reset with both stages full.
        rdy_mode = 1;
        @(posedge clk);
        #2;
        for (int n = 0; n < 3; n++) begin
            gen(cw, e);
            in_cw = cw;
            in_valid = 1;
            @(negedge clk);
            if (in_ready) sb.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        chk("mid_full", 32'({out_valid, in_ready}), 32'b10);
        rst_n = 0;
        @(posedge clk);
        #1;
        sb.delete();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_data", 32'({out_data, out_syndrome, out_single_err, out_double_err}), 32'd0);
`ifdef HAMMING_DEC_ERR_CNT_EN
        chk("mid_rst_counts", 32'({sec_count, ded_count}), 32'd0);
`endif
        rst_n = 1;
        rdy_mode = 2;
        send(8'hAB, '{d: 4'b1011, s: 3'd0, se: 1'b1, de: 1'b0});
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
